// File: rtl/lector_contador_if.sv
// Request/response handshake between the counter reader and the contador stage.
// The reader drives req/idx; the contador stage answers with valid_contador/contador_out.
interface lector_contador_if;
   logic       req;
   logic [1:0] idx;
   logic       valid_contador;
   logic [4:0] contador_out;

   modport master (
      output req,
      output idx,
      input  valid_contador,
      input  contador_out
   );

   modport slave (
      input  req,
      input  idx,
      output valid_contador,
      output contador_out
   );
endinterface

// File: rtl/lector_contador.sv
// Sequentially reads the pop counts of FIFOs 0..3 while IDLE is high and holds them.
// Define LECTOR_TIMEOUT_EN to add a 16-cycle response timeout that flags error.
module lector_contador (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      IDLE,
   lector_contador_if.master         bus,
   output logic [4:0]                cuenta_0,
   output logic [4:0]                cuenta_1,
   output logic [4:0]                cuenta_2,
   output logic [4:0]                cuenta_3,
   output logic                      done,
   output logic                      error
);

   typedef enum logic [1:0] {ESPERA, PEDIR, PAUSA, FIN} state_t;

   state_t     state_q, state_d;
   logic       req_q, req_d;
   logic [1:0] idx_q, idx_d;
   logic       done_q, done_d;
   logic [4:0] cuenta_q [4];
   logic [4:0] cuenta_d [4];
   logic       take;
   logic [4:0] take_val;

`ifdef LECTOR_TIMEOUT_EN
   logic       error_q, error_d;
   logic [3:0] tmo_q, tmo_d;
`endif

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      idx_d    = idx_q;
      done_d   = done_q;
      cuenta_d = cuenta_q;
      take     = 1'b0;
      take_val = bus.contador_out;
`ifdef LECTOR_TIMEOUT_EN
      error_d  = error_q;
      tmo_d    = tmo_q;
`endif
      case (state_q)
         ESPERA: begin
            req_d  = 1'b0;
            done_d = 1'b0;
            if (IDLE) begin
               state_d = PEDIR;
               idx_d   = 2'd0;
               req_d   = 1'b1;
`ifdef LECTOR_TIMEOUT_EN
               error_d = 1'b0;
               tmo_d   = 4'd0;
`endif
            end
         end
         PEDIR: begin
            if (!IDLE) begin
               // Abort keeps whatever was already captured.
               state_d = ESPERA;
               req_d   = 1'b0;
               done_d  = 1'b0;
            end else begin
               if (bus.valid_contador) begin
                  take = 1'b1;
`ifdef LECTOR_TIMEOUT_EN
               end else if (tmo_q == 4'hF) begin
                  take     = 1'b1;
                  take_val = 5'h1F;
                  error_d  = 1'b1;
               end else begin
                  tmo_d = tmo_q + 4'd1;
`endif
               end
               if (take) begin
                  cuenta_d[idx_q] = take_val;
                  req_d           = 1'b0;
                  if (idx_q == 2'd3) begin
                     state_d = FIN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = PAUSA;
                  end
               end
            end
         end
         PAUSA: begin
            if (!IDLE) begin
               state_d = ESPERA;
               req_d   = 1'b0;
               done_d  = 1'b0;
            end else begin
               state_d = PEDIR;
               idx_d   = idx_q + 2'd1;
               req_d   = 1'b1;
`ifdef LECTOR_TIMEOUT_EN
               tmo_d   = 4'd0;
`endif
            end
         end
         FIN: begin
            req_d  = 1'b0;
            done_d = IDLE;
            if (!IDLE) state_d = ESPERA;
         end
         default: begin
            state_d = ESPERA;
            req_d   = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ESPERA;
         req_q   <= 1'b0;
         idx_q   <= 2'd0;
         done_q  <= 1'b0;
         for (int i = 0; i < 4; i++) cuenta_q[i] <= 5'd0;
`ifdef LECTOR_TIMEOUT_EN
         error_q <= 1'b0;
         tmo_q   <= 4'd0;
`endif
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
         cuenta_q <= cuenta_d;
`ifdef LECTOR_TIMEOUT_EN
         error_q  <= error_d;
         tmo_q    <= tmo_d;
`endif
      end
   end

   assign bus.req  = req_q;
   assign bus.idx  = idx_q;
   assign done     = done_q;
   assign cuenta_0 = cuenta_q[0];
   assign cuenta_1 = cuenta_q[1];
   assign cuenta_2 = cuenta_q[2];
   assign cuenta_3 = cuenta_q[3];
`ifdef LECTOR_TIMEOUT_EN
   assign error    = error_q;
`else
   assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_lector_contador.sv
// Self-checking bench for lector_contador: vector table of read sequences plus
// hand-written abort, reset and timeout sequences.
module tb_lector_contador;

   logic       clk = 1'b0;
   logic       reset;
   logic       IDLE;
   logic [4:0] cuenta_0, cuenta_1, cuenta_2, cuenta_3;
   logic       done, error;

   always #5 clk = ~clk;

   lector_contador_if bus ();

   lector_contador dut (
      .clk      (clk),
      .reset    (reset),
      .IDLE     (IDLE),
      .bus      (bus),
      .cuenta_0 (cuenta_0),
      .cuenta_1 (cuenta_1),
      .cuenta_2 (cuenta_2),
      .cuenta_3 (cuenta_3),
      .done     (done),
      .error    (error)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      int idx;
      int val;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [3:0][4:0] resp;
      logic [3:0][3:0] dly;
      bit              junk;
      logic [3:0][4:0] exp_c;
      int              exp_done;
   } vec_t;

   vec_t vecs[3];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int cuenta_of(input int i);
      case (i)
         0:       return int'(cuenta_0);
         1:       return int'(cuenta_1);
         2:       return int'(cuenta_2);
         default: return int'(cuenta_3);
      endcase
   endfunction

   function automatic vec_t mk(input int r0, r1, r2, r3, d0, d1, d2, d3,
                               input bit junk, input int e0, e1, e2, e3, edone);
      vec_t v;
      v.resp[0] = r0[4:0]; v.resp[1] = r1[4:0]; v.resp[2] = r2[4:0]; v.resp[3] = r3[4:0];
      v.dly[0]  = d0[3:0]; v.dly[1]  = d1[3:0]; v.dly[2]  = d2[3:0]; v.dly[3]  = d3[3:0];
      v.exp_c[0] = e0[4:0]; v.exp_c[1] = e1[4:0]; v.exp_c[2] = e2[4:0]; v.exp_c[3] = e3[4:0];
      v.junk     = junk;
      v.exp_done = edone;
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   // Called at the negedge where req for index k is visible; returns at the
   // negedge where the next index request should be visible.
   task automatic respond(input int k, input int val);
      tick();
      bus.valid_contador = 1'b1;
      bus.contador_out   = val[4:0];
      tick();
      bus.valid_contador = 1'b0;
      chk("respond_req_low", int'(bus.req), 0);
      chk("respond_capture", cuenta_of(k), val);
      tick();
   endtask

   task automatic run_vec(input vec_t v, input int n);
      int  cyc;
      int  wv;
      exp_t e;
      IDLE = 1'b1;
      tick();
      cyc = 1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("v%0d_req_k%0d", n, k), int'(bus.req), 1);
         chk($sformatf("v%0d_idx_k%0d", n, k), int'(bus.idx), k);
         for (int d = 0; d < int'(v.dly[k]); d++) begin
            tick();
            cyc++;
            chk($sformatf("v%0d_hold_req_k%0d", n, k), int'(bus.req), 1);
            chk($sformatf("v%0d_hold_idx_k%0d", n, k), int'(bus.idx), k);
         end
         bus.valid_contador = 1'b1;
         bus.contador_out   = v.resp[k];
         wv = int'(v.resp[k]);
         exp_q.push_back('{idx: k, val: wv});
         tick();
         cyc++;
         // Junk response while in the pause / finish state must be ignored.
         bus.valid_contador = v.junk;
         bus.contador_out   = ~v.resp[k];
         chk($sformatf("v%0d_req_low_k%0d", n, k), int'(bus.req), 0);
         e = exp_q.pop_front();
         chk($sformatf("v%0d_cuenta_%0d", n, e.idx), cuenta_of(e.idx), e.val);
         chk($sformatf("v%0d_done_k%0d", n, k), int'(done), (k == 3) ? 1 : 0);
         if (k == 3) chk($sformatf("v%0d_done_cycle", n), cyc, v.exp_done);
         if (k < 3) begin
            tick();
            cyc++;
            bus.valid_contador = 1'b0;
         end
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         bus.valid_contador = 1'b0;
         chk($sformatf("v%0d_fin_done", n), int'(done), 1);
         chk($sformatf("v%0d_fin_req", n), int'(bus.req), 0);
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("v%0d_final_cuenta_%0d", n, i), cuenta_of(i), int'(v.exp_c[i]));
      IDLE = 1'b0;
      tick();
      chk($sformatf("v%0d_done_clear", n), int'(done), 0);
      chk($sformatf("v%0d_req_idle", n), int'(bus.req), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(0, 1, 3, 1,   1, 1, 1, 1, 1'b0, 0, 1, 3, 1,   12);
      vecs[1] = mk(8, 31, 0, 14, 4, 4, 4, 4, 1'b1, 8, 31, 0, 14,  24);
      vecs[2] = mk(31, 16, 5, 30, 1, 2, 3, 1, 1'b1, 31, 16, 5, 30, 15);

      reset = 1'b1;
      IDLE  = 1'b0;
      bus.valid_contador = 1'b0;
      bus.contador_out   = 5'd0;

      // Reset with IDLE low: everything zero, req never asserts.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_req", int'(bus.req), 0);
      end
      chk("rst_idx", int'(bus.idx), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_error", int'(error), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_cuenta_%0d", i), cuenta_of(i), 0);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("idle_low_req", int'(bus.req), 0);
      end

      for (int n = 0; n < 3; n++) run_vec(vecs[n], n);

      // Abort at idx=2 after 0,1 captured; cuenta_2/3 keep prior values (5, 30).
      IDLE = 1'b1;
      tick();
      chk("abort_req0", int'(bus.req), 1);
      respond(0, 5);
      respond(1, 6);
      chk("abort_idx2", int'(bus.idx), 2);
      chk("abort_req2", int'(bus.req), 1);
      IDLE = 1'b0;
      tick();
      chk("abort_req", int'(bus.req), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_c0", int'(cuenta_0), 5);
      chk("abort_c1", int'(cuenta_1), 6);
      chk("abort_c2", int'(cuenta_2), 5);
      chk("abort_c3", int'(cuenta_3), 30);
      IDLE = 1'b1;
      tick();
      chk("restart_req", int'(bus.req), 1);
      chk("restart_idx", int'(bus.idx), 0);

      // Reset in PEDIR idx=1 with valid on the same edge: nothing captured.
      respond(0, 7);
      chk("rstmid_idx1", int'(bus.idx), 1);
      bus.valid_contador = 1'b1;
      bus.contador_out   = 5'd9;
      reset = 1'b1;
      IDLE  = 1'b0;
      tick();
      bus.valid_contador = 1'b0;
      chk("rstmid_req", int'(bus.req), 0);
      chk("rstmid_idx", int'(bus.idx), 0);
      chk("rstmid_done", int'(done), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("rstmid_cuenta_%0d", i), cuenta_of(i), 0);
      reset = 1'b0;
      tick();
      chk("rstmid_after_req", int'(bus.req), 0);

      // No response for idx=1.
      IDLE = 1'b1;
      tick();
      respond(0, 2);
      chk("tmo_idx1", int'(bus.idx), 1);
`ifdef LECTOR_TIMEOUT_EN
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("tmo_wait_req", int'(bus.req), 1);
      end
      tick();
      chk("tmo_req_low", int'(bus.req), 0);
      chk("tmo_c1", int'(cuenta_1), 31);
      chk("tmo_error", int'(error), 1);
      tick();
      respond(2, 4);
      tick();
      bus.valid_contador = 1'b1;
      bus.contador_out   = 5'd5;
      tick();
      bus.valid_contador = 1'b0;
      chk("tmo_c3", int'(cuenta_3), 5);
      chk("tmo_done", int'(done), 1);
      chk("tmo_error_sticky", int'(error), 1);
      IDLE = 1'b0;
      tick();
      IDLE = 1'b1;
      tick();
      chk("tmo_error_clear", int'(error), 0);
      IDLE = 1'b0;
      tick();
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("notmo_req_high", int'(bus.req), 1);
         chk("notmo_error", int'(error), 0);
      end
      chk("notmo_idx", int'(bus.idx), 1);
      reset = 1'b1;
      IDLE  = 1'b0;
      tick();
      reset = 1'b0;
`endif
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lector_contador.md
LECTOR_CONTADOR -- requirements
Module: lector_contador

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 IDLE  input  1  high = FIFOs quiescent; counter read sequence permitted.
REQ-005 valid_contador  input  1  counter response strobe from the contador stage.
REQ-006 contador_out  input  5  pop count for the currently requested idx; meaningful only with valid_contador=1.
REQ-007 req  output  1  read request to the contador stage.
REQ-008 idx  output  2  FIFO index requested (0..3).
REQ-009 cuenta_0, cuenta_1, cuenta_2, cuenta_3  output  5 each  captured pop counts for FIFO 0..3.
REQ-010 done  output  1  level; all four counts captured in the current IDLE window.
REQ-011 error  output  1  sticky timeout flag; see Configuration.

Function
REQ-012 SHALL register all outputs; no combinational input-to-output path.
REQ-013 SHALL implement FSM states ESPERA, PEDIR, PAUSA, FIN.
REQ-014 ESPERA: req=0, done=0; when IDLE=1 is sampled, load idx=0, req=1, clear error, and go to PEDIR (req visible one cycle after IDLE is sampled).
REQ-015 PEDIR: hold req=1 and idx stable until valid_contador=1 is sampled.
REQ-016 PEDIR, valid_contador=1 sampled: cuenta_<idx> SHALL be loaded with contador_out at that edge, and req SHALL be 0 from that edge on.
REQ-017 PEDIR, same edge, idx<3: go to PAUSA; idx<3 increments idx at the PAUSA exit edge.
REQ-018 PEDIR, same edge, idx==3: go to FIN.
REQ-019 PAUSA: lasts exactly one cycle with req=0; then idx+1 and req=1, back to PEDIR.
REQ-020 Result: minimum 3 cycles per index; minimum 12 cycles from the first req to done when valid returns one cycle after req.
REQ-021 FIN: done=1 and req=0 while IDLE=1; on IDLE=0 sampled, done=0 and go to ESPERA; FIN SHALL never restart a sequence without IDLE first going low.
REQ-022 IDLE=0 sampled in PEDIR or PAUSA: abort to ESPERA, req=0, done=0; already-captured cuenta_x values are retained and uncaptured ones are unchanged.
REQ-023 valid_contador SHALL be ignored in ESPERA, PAUSA and FIN; cuenta_x change only per REQ-016 or REQ-028.
REQ-024 contador_out SHALL be stored unmodified, full 5 bits (0..31); no saturation or arithmetic.

Reset
REQ-025 reset=1 sampled: state=ESPERA, req=0, idx=0, done=0, error=0, cuenta_0..3=0, timeout counter=0.
REQ-026 reset SHALL take priority over every other input, including mid-sequence; any in-flight request is dropped without capture.

Configuration
REQ-027 Macro LECTOR_TIMEOUT_EN SHALL compile in the response timeout.
REQ-028 Defined: a 4-bit counter clears on PEDIR entry and increments each PEDIR cycle without valid; at 16 cycles, cuenta_<idx>=5'h1F, error=1 (sticky until the next sequence start or reset), and the FSM advances as if valid arrived.
REQ-029 Undefined: PEDIR waits indefinitely; error SHALL be tied to 0 and the port retained.

Verification
REQ-030 Reset 3 cycles, IDLE=0 -> all outputs 0, req never asserts.
REQ-031 IDLE=1; valid responds one cycle after each req with 0,1,3,1 -> cuenta_0..3=0,1,3,1; idx sequence 0,1,2,3; one req-low cycle between indexes; done=1 12 cycles after the first req; done clears one cycle after IDLE=0.
REQ-032 IDLE=1; responses 8,31,0,14 with valid delayed 4 cycles each -> cuentas=8,31,0,14; req held, idx stable during each wait.
REQ-033 Drop IDLE while idx=2 is in PEDIR after 0,1 are captured -> req=0 next cycle, done=0, cuenta_0/1 updated, cuenta_2/3 keep prior values; next IDLE restarts at idx=0.
REQ-034 Assert reset while in PEDIR idx=1 with valid=1 on the same edge -> no capture, all outputs 0.
REQ-035 LECTOR_TIMEOUT_EN defined, no valid for idx=1 -> after 16 cycles, cuenta_1=31, error=1, sequence completes and done=1; without the macro, req stays high indefinitely with error=0.
